// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset core: opcodes,
// function codes, FSM states, ALU operations and instruction field slices.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  function automatic logic [5:0] f_op(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] i);
    return i[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] i);
    return i[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] i);
    return i[15:0];
  endfunction

  function automatic logic [25:0] f_addr(input logic [31:0] i);
    return i[25:0];
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU: arithmetic/logic on a,b; shifts move b by shamt.
module mc_alu
  import mc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    shamt,
  input  alu_op_t       alu_op,
  output logic [DW-1:0] y
);

  // Select the result for the requested operation; arithmetic wraps mod 2^DW.
  always_comb begin
    y = '0;
    case (alu_op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = ($signed(a) < $signed(b)) ? DW'(1) : '0;
      ALU_SLL: y = b << shamt;
      ALU_SRL: y = b >> shamt;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle MIPS-subset core with a shared word-addressed memory port.
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB); HALT and TRAP are terminal.
module mc_core
  import mc_pkg::*;
#(
  parameter int             DW       = 32,
  parameter int             AW       = 12,
  parameter int             NREGS    = 32,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata,
  output logic          retire,
  output logic          halted,
  output logic          illegal,
  output logic [AW-1:0] pc_out
);

  state_t          state_reg, state_next;
  logic [AW-1:0]   pc_reg;
  logic [31:0]     instr_reg;
  logic [DW-1:0]   op_a_reg, op_b_reg, res_reg;
  // r0 is not stored: it reads as zero and writes to it fall away.
  logic [DW-1:0]   regs [1:NREGS-1];

  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, shamt, wb_idx;
  logic [15:0]     imm;
  logic            legal, is_sw, br_taken;
  alu_op_t         alu_op;
  logic [DW-1:0]   imm_dw, alu_b, alu_y;
  logic [AW-1:0]   imm_aw, pc_inc, pc_jump;

  assign op      = f_op(instr_reg);
  assign rs      = f_rs(instr_reg);
  assign rt      = f_rt(instr_reg);
  assign rd      = f_rd(instr_reg);
  assign shamt   = f_shamt(instr_reg);
  assign funct   = f_funct(instr_reg);
  assign imm     = f_imm(instr_reg);
  assign imm_dw  = DW'($signed(imm));
  assign imm_aw  = AW'($signed(imm));
  assign pc_inc  = pc_reg + AW'(1);
  assign pc_jump = AW'(f_addr(instr_reg));
  assign is_sw   = (op == OP_SW);
  assign wb_idx  = (op == OP_RTYPE) ? rd : rt;
  assign alu_b   = (op == OP_RTYPE) ? op_b_reg : imm_dw;
  assign br_taken = ((op == OP_BEQ) && (op_a_reg == op_b_reg)) ||
                    ((op == OP_BNE) && (op_a_reg != op_b_reg));

  assign halted  = (state_reg == S_HALT) || (state_reg == S_TRAP);
  assign illegal = (state_reg == S_TRAP);
  assign pc_out  = pc_reg;

  function automatic logic idx_ok(input logic [4:0] idx);
    return 32'(idx) < NREGS;
  endfunction

  // Register read; r0 and indices without storage return zero.
  function automatic logic [DW-1:0] rd_reg(input logic [4:0] idx);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 1; i < NREGS; i++)
      if (idx == 5'(i)) v = regs[i];
    return v;
  endfunction

  mc_alu #(.DW(DW)) u_alu (
    .a      (op_a_reg),
    .b      (alu_b),
    .shamt  (shamt),
    .alu_op (alu_op),
    .y      (alu_y)
  );

  // Decode legality and ALU operation from opcode/funct and register indices.
  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        legal = idx_ok(rs) && idx_ok(rt) && idx_ok(rd);
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          default: legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: legal = idx_ok(rs) && idx_ok(rt);
      OP_J, OP_HALT:                          legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // Next state and memory/retire outputs; reset silences the port at once.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc_reg;
    mem_wdata  = '0;
    retire     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        case (op)
          OP_LW, OP_SW:         state_next = S_MEM;
          OP_BEQ, OP_BNE, OP_J: begin retire = 1'b1; state_next = S_FETCH; end
          OP_HALT:              begin retire = 1'b1; state_next = S_HALT;  end
          default:              state_next = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_sw;
        mem_addr = AW'(res_reg);
        if (is_sw) mem_wdata = op_b_reg;
        if (mem_ready) begin
          if (is_sw) begin retire = 1'b1; state_next = S_FETCH; end
          else       state_next = S_WB;
        end
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      retire  = 1'b0;
    end
  end

  // Datapath registers: instruction latch, operands, result and PC update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        S_FETCH:  if (mem_ready) instr_reg <= mem_rdata;
        S_DECODE: begin
          op_a_reg <= rd_reg(rs);
          op_b_reg <= rd_reg(rt);
        end
        S_EXEC: begin
          res_reg <= alu_y;
          if (op == OP_J)                        pc_reg <= pc_jump;
          else if (op == OP_BEQ || op == OP_BNE) pc_reg <= br_taken ? pc_inc + imm_aw : pc_inc;
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_sw) pc_reg  <= pc_inc;
            else       res_reg <= DW'(mem_rdata);
          end
        end
        S_WB:    pc_reg <= pc_inc;
        default: ;
      endcase
    end
  end

  // Register file write-back to rd (R-type) or rt (addi, lw).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) regs[i] <= '0;
    end else if (state_reg == S_WB) begin
      for (int i = 1; i < NREGS; i++)
        if (wb_idx == 5'(i)) regs[i] <= res_reg;
    end
  end

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core (DW=16, NREGS=8): scoreboards of expected
// retirements and stores, checked as the core produces them.
module tb_mc_core;
  import mc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int NREGS = 8;

  logic          clk, rst_n;
  logic          mem_req, mem_we, mem_ready, retire, halted, illegal;
  logic [AW-1:0] mem_addr, pc_out;
  logic [DW-1:0] mem_wdata;
  logic [31:0]   mem_rdata;
  logic [31:0]   mem [4096];

  typedef struct { int pc; int cyc; } ret_t;
  typedef struct { int addr; int data; } wr_t;
  ret_t rq[$];
  wr_t  wq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic found;

  mc_core #(.DW(DW), .AW(AW), .NREGS(NREGS), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .retire(retire), .halted(halted),
    .illegal(illegal), .pc_out(pc_out)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input int rs,
                                        input int rt, input int imm);
    return {opc, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int addr);
    return {OP_J, 26'(addr)};
  endfunction

  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [31:0] BAD_W  = 32'hF800_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample mid-cycle (retire/store scoreboards, memory write),
  // then return 2 time units after the next rising edge.
  task automatic tick();
    ret_t r;
    wr_t  w;
    @(negedge clk);
    if (!rst_n) begin
      cyc = 0;
    end else begin
      if (retire) begin
        $display("retire pc=%0d cycle=%0d", pc_out, cyc);
        chk("retire_expected", 32'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          r = rq.pop_front();
          chk("retire_pc", 32'(pc_out), r.pc);
          if (r.cyc >= 0) chk("retire_cycle", cyc, r.cyc);
        end
      end
      if (mem_req && mem_we && mem_ready) begin
        $display("store addr=0x%0h data=0x%0h cycle=%0d", mem_addr, mem_wdata, cyc);
        mem[mem_addr] = 32'(mem_wdata);
        chk("store_expected", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("store_addr", 32'(mem_addr), w.addr);
          chk("store_data", 32'(mem_wdata), w.data);
        end
      end
      cyc++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = HALT_W;
  endtask

  task automatic exp_ret(input int pc, input int c);
    ret_t r;
    r.pc = pc; r.cyc = c;
    rq.push_back(r);
  endtask

  task automatic exp_wr(input int a, input int d);
    wr_t w;
    w.addr = a; w.data = d;
    wq.push_back(w);
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_until_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    chk("halt_reached", 32'(halted), 1);
  endtask

  task automatic drain_check(input string tag);
    chk({tag, "_retires_left"}, rq.size(), 0);
    chk({tag, "_stores_left"}, wq.size(), 0);
    rq.delete();
    wq.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ready = 1'b1;
    clear_mem();
    @(posedge clk);
    #2;

    // Test 1: basic program, zero-wait memory, exact retire cycles.
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 5);
    mem[1] = enc_i(OP_ADDI, 0, 2, 7);
    mem[2] = enc_r(1, 2, 3, 0, FN_ADD);
    mem[3] = enc_i(OP_SW, 0, 3, 16'h10);
    mem[4] = HALT_W;
    hold_reset();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_retire", 32'(retire), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_pc_out", 32'(pc_out), 0);
    exp_ret(0, 3); exp_ret(1, 7); exp_ret(2, 11); exp_ret(3, 15); exp_ret(4, 18);
    exp_wr(16'h10, 12);
    rst_n = 1'b1;
    run_until_halt(60);
    chk("t1_illegal", 32'(illegal), 0);
    chk("t1_pc_out", 32'(pc_out), 4);
    chk("t1_mem10", mem[16'h10], 12);
    tick(); tick(); tick();
    chk("t1_halt_no_req", 32'(mem_req), 0);
    chk("t1_halt_stays", 32'(halted), 1);
    drain_check("t1");

    // Test 2: lw with three wait cycles on the data access.
    clear_mem();
    mem[0] = enc_i(OP_LW, 0, 1, 16'h20);
    mem[1] = enc_i(OP_SW, 0, 1, 16'h21);
    mem[2] = HALT_W;
    mem[16'h20] = 32'h1234_BEEF;
    hold_reset();
    exp_ret(0, 7); exp_ret(1, 11); exp_ret(2, 14);
    exp_wr(16'h21, 16'hBEEF);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_req && !mem_we && mem_addr == 12'h020) found = 1'b1;
      else tick();
    end
    chk("t2_data_req_seen", 32'(found), 1);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_wait_req", 32'(mem_req), 1);
      chk("t2_wait_addr", 32'(mem_addr), 32'h20);
    end
    mem_ready = 1'b1;
    run_until_halt(40);
    drain_check("t2");

    // Test 3: jump, taken bne, not-taken beq, self-looping beq.
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 3);
    mem[1] = enc_i(OP_ADDI, 0, 2, 9);
    mem[2] = enc_j(4);
    mem[4] = enc_i(OP_BNE, 1, 2, 2);
    mem[7] = enc_i(OP_BEQ, 1, 2, -1);
    mem[8] = enc_i(OP_BEQ, 1, 1, -1);
    hold_reset();
    exp_ret(0, 3); exp_ret(1, 7); exp_ret(2, 10); exp_ret(4, 13);
    exp_ret(7, 16); exp_ret(8, 19); exp_ret(8, 22); exp_ret(8, 25);
    rst_n = 1'b1;
    for (int i = 0; i < 60 && rq.size() != 0; i++) tick();
    chk("t3_loop_pc", 32'(pc_out), 8);
    chk("t3_not_halted", 32'(halted), 0);
    drain_check("t3");

    // Test 4: 16-bit arithmetic, shifts, slt, r0 discard.
    clear_mem();
    mem[0]  = enc_i(OP_ADDI, 0, 5, 1);
    mem[1]  = enc_r(0, 5, 1, 0, FN_SUB);
    mem[2]  = enc_r(1, 0, 2, 0, FN_SLT);
    mem[3]  = enc_r(0, 1, 3, 4, FN_SRL);
    mem[4]  = enc_i(OP_ADDI, 0, 0, 16'h55);
    mem[5]  = enc_r(0, 0, 4, 0, FN_ADD);
    mem[6]  = enc_r(0, 5, 6, 3, FN_SLL);
    mem[7]  = enc_r(2, 6, 7, 0, FN_OR);
    mem[8]  = enc_i(OP_SW, 0, 1, 16'h30);
    mem[9]  = enc_i(OP_SW, 0, 2, 16'h31);
    mem[10] = enc_i(OP_SW, 0, 3, 16'h32);
    mem[11] = enc_i(OP_SW, 0, 4, 16'h33);
    mem[12] = enc_i(OP_SW, 0, 7, 16'h34);
    mem[13] = HALT_W;
    hold_reset();
    for (int p = 0; p < 14; p++) exp_ret(p, -1);
    exp_wr(16'h30, 16'hFFFF); exp_wr(16'h31, 1); exp_wr(16'h32, 16'h0FFF);
    exp_wr(16'h33, 0); exp_wr(16'h34, 9);
    rst_n = 1'b1;
    run_until_halt(120);
    drain_check("t4");

    // Test 5: unknown opcode 0x3E at pc 9 traps without retiring.
    clear_mem();
    mem[0] = enc_j(9);
    mem[9] = BAD_W;
    hold_reset();
    exp_ret(0, 2);
    rst_n = 1'b1;
    run_until_halt(30);
    tick(); tick(); tick();
    chk("t5_illegal", 32'(illegal), 1);
    chk("t5_pc_frozen", 32'(pc_out), 9);
    chk("t5_no_req", 32'(mem_req), 0);
    drain_check("t5");

    // Test 6: rd=9 exceeds the 8-register file.
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 1);
    mem[1] = enc_r(1, 1, 9, 0, FN_ADD);
    hold_reset();
    exp_ret(0, 3);
    rst_n = 1'b1;
    run_until_halt(30);
    chk("t6_illegal", 32'(illegal), 1);
    chk("t6_pc_frozen", 32'(pc_out), 1);
    drain_check("t6");

    // Test 7: reset during a stalled fetch, then registers read zero.
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 5);
    mem[1] = enc_i(OP_ADDI, 0, 2, 7);
    hold_reset();
    exp_ret(0, 3); exp_ret(1, 7);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && rq.size() != 0; i++) tick();
    mem_ready = 1'b0;
    tick(); tick();
    chk("t7_fetch_wait_req", 32'(mem_req), 1);
    chk("t7_fetch_wait_addr", 32'(mem_addr), 2);
    rst_n = 1'b0;
    #1;
    chk("t7_async_req_drop", 32'(mem_req), 0);
    chk("t7_async_addr", 32'(mem_addr), 0);
    chk("t7_async_pc", 32'(pc_out), 0);
    drain_check("t7a");
    clear_mem();
    mem[0] = enc_i(OP_SW, 0, 1, 16'h40);
    mem[1] = enc_i(OP_SW, 0, 2, 16'h41);
    mem[2] = HALT_W;
    mem_ready = 1'b1;
    tick();
    exp_ret(0, 3); exp_ret(1, 7); exp_ret(2, 10);
    exp_wr(16'h40, 0); exp_wr(16'h41, 0);
    rst_n = 1'b1;
    run_until_halt(40);
    drain_check("t7b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_core.md
Name: mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS-subset CPU.
- Fetches 32-bit instructions and data over one shared word-addressed memory port with a req/ready handshake, instead of internal RAM.
- Executes R/I/J instructions through an FSM, with configurable data width, register count and address width.
- Adds halt, illegal-instruction trap and a retire pulse for top-level integration and verification.

Parameters:
- DW, 32, datapath/register width in bits (>=16).
- AW, 12, memory word-address width.
- NREGS, 32, number of architectural registers (2..32).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- mem_req  out  1  memory request valid
- mem_we  out  1  1=write, 0=read (qualified by mem_req)
- mem_addr  out  AW  word address
- mem_wdata  out  DW  store data
- mem_ready  in  1  request accepted/completed this cycle; read data valid
- mem_rdata  in  32  read data (low DW bits used for loads)
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  core stopped (HALT or trap)
- illegal  out  1  stopped due to illegal instruction
- pc_out  out  AW  current PC

Behaviour:
- Reset (async assert): state=FETCH, pc=RESET_PC, all registers=0; mem_req, mem_we, retire, halted, illegal = 0; mem_addr=RESET_PC; mem_wdata=0. Any outstanding transaction is abandoned; mem_req drops in the same cycle.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Address and request held stable until mem_ready=1 is sampled; instr latched on that edge; go to DECODE.
- DECODE: read rs/rt operands.
  - rs, rt or rd index >= NREGS → TRAP.
  - Unknown opcode/funct → TRAP.
- EXEC:
  - R-type → WB.
  - addi → WB.
  - lw/sw → MEM.
  - beq/bne: if taken, pc = pc+1+sext(imm); otherwise pc = pc+1. retire pulses; → FETCH.
  - j: pc = addr[AW-1:0]; retire; → FETCH.
  - opcode 0x3F: → HALT; retire pulses.
- MEM:
  - mem_req=1, mem_addr = (reg[rs]+sext(imm)) truncated to AW, mem_we=1 for sw with mem_wdata=reg[rt].
  - Held until mem_ready. lw → WB; sw → retire, pc+1, → FETCH.
- WB: write result to rd (R-type) or rt (addi, lw); retire; pc+1; → FETCH.
- Register 0 reads as 0; writes to it are discarded.
- Instruction set:
  - R-type (op 0x00), funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02 (by shamt).
  - I-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - J-type: j 0x02.
- Arithmetic: modulo 2^DW, no overflow trap. sext(imm) extends 16 bits to DW.
- PC wraps modulo 2^AW.
- Latency with zero-wait memory (mem_ready tied 1):
  - R-type/addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne/j: 3 cycles.
  - Each wait cycle adds one.
- HALT: halted=1, no requests, stays until reset.
- TRAP: halted=1, illegal=1, pc frozen at the faulting instruction, no retire.
- mem_ready while mem_req=0 is ignored.

Decomposition:
- Shared package mc_pkg:
  - opcode/funct localparams;
  - state enum;
  - ALU op enum;
  - instruction field slice functions.
- One sub-module, mc_alu: combinational, parametrised by DW. Inputs a, b, shamt, alu_op; output y.
- Register file stays inline.

Test Plan:
- Zero-wait memory; program at 0: addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x10(r0); halt → mem[0x10]=12, halted=1, 5 retire pulses, total 4+4+4+4+3 cycles.
- lw with mem_ready low for 3 cycles on the data access → mem_req/mem_addr stable throughout; reg written on the WB after ready; lw latency = 8 cycles.
- beq r1,r1,-1 at pc=4 → pc returns to 4; with r1≠r2, beq r1,r2,-1 → pc=5; bne r1,r2,+2 at 4 → pc=7.
- sub r1,r0,1 with DW=16 → r1=0xFFFF; slt r2,r1,r0 → 1; srl r3,r1,4 → 0x0FFF.
- Write to r0, then add r4,r0,r0 → r4=0. Opcode 0x3E at pc=9 → illegal=1, halted=1, pc_out=9, no retire. NREGS=8 with rd=9 → trap.
- Assert rst_n mid-FETCH wait → mem_req=0 immediately. On release, fetch restarts at RESET_PC and registers read 0.
